mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 214 +++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 signed multiply (radix-2 Booth) and signed
// restoring divide. Both operations take 32 cycles, one bit per cycle, and
// share a single accumulator datapath.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start_mult / start_div; divide-by-zero resolved here
// ST_MULT | Booth iterations, {acc_hi, acc_lo, booth_x} shifts right
// ST_DIV  | restoring iterations on magnitudes, {rem, quo} shifts left
module mult_div_unit (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'd31;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Multiply: acc_hi is the 33-bit Booth upper half (extra bit absorbs
  // the +/-2^31 swing), acc_lo the multiplier being shifted out.
  // Divide: acc_hi is the partial remainder, acc_lo the dividend/quotient.
  logic [32:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic        booth_x_q, booth_x_d;
  // Multiplicand (multiply) or divisor magnitude (divide).
  logic [31:0] opb_q, opb_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] opb_sext;
  logic [32:0] booth_sum;
  logic [32:0] mult_hi_nxt;
  logic [31:0] mult_lo_nxt;
  logic        mult_x_nxt;
  logic [32:0] rem_shift;
  logic [32:0] rem_trial;
  logic [32:0] div_rem_nxt;
  logic [31:0] div_quo_nxt;
  logic [31:0] quo_final;
  logic [31:0] rem_final;

  assign a_mag    = A[31] ? (~A + 32'd1) : A;
  assign b_mag    = B[31] ? (~B + 32'd1) : B;
  assign opb_sext = {opb_q[31], opb_q};

  // One Booth step: add/subtract the multiplicand, then arithmetic shift right.
  always_comb begin
    booth_sum = acc_hi_q;
    case ({acc_lo_q[0], booth_x_q})
      2'b01:   booth_sum = acc_hi_q + opb_sext;
      2'b10:   booth_sum = acc_hi_q - opb_sext;
      default: booth_sum = acc_hi_q;
    endcase
    mult_hi_nxt = {booth_sum[32], booth_sum[32:1]};
    mult_lo_nxt = {booth_sum[0], acc_lo_q[31:1]};
    mult_x_nxt  = acc_lo_q[0];
  end

  // One restoring-division step on magnitudes, plus final sign fix-up.
  always_comb begin
    rem_shift = {acc_hi_q[31:0], acc_lo_q[31]};
    rem_trial = rem_shift - {1'b0, opb_q};
    if (!rem_trial[32]) begin
      div_rem_nxt = rem_trial;
      div_quo_nxt = {acc_lo_q[30:0], 1'b1};
    end else begin
      div_rem_nxt = rem_shift;
      div_quo_nxt = {acc_lo_q[30:0], 1'b0};
    end
    quo_final = neg_quo_q ? (~div_quo_nxt + 32'd1) : div_quo_nxt;
    rem_final = neg_rem_q ? (~div_rem_nxt[31:0] + 32'd1) : div_rem_nxt[31:0];
  end

  // Next-state and next-output computation for the controller.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    booth_x_d = booth_x_q;
    opb_d     = opb_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (start_mult) begin
          state_d   = ST_MULT;
          cnt_d     = 6'd0;
          acc_hi_d  = 33'd0;
          acc_lo_d  = A;
          booth_x_d = 1'b0;
          opb_d     = B;
          busy_d    = 1'b1;
          dz_d      = 1'b0;
        end else if (start_div) begin
          if (B == 32'd0) begin
            // Resolved immediately: flag it, pulse done, keep HI/LO.
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d   = ST_DIV;
            cnt_d     = 6'd0;
            acc_hi_d  = 33'd0;
            acc_lo_d  = a_mag;
            opb_d     = b_mag;
            neg_quo_d = A[31] ^ B[31];
            neg_rem_d = A[31];
            busy_d    = 1'b1;
            dz_d      = 1'b0;
          end
        end
      end

      ST_MULT: begin
        acc_hi_d  = mult_hi_nxt;
        acc_lo_d  = mult_lo_nxt;
        booth_x_d = mult_x_nxt;
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          hi_d    = mult_hi_nxt[31:0];
          lo_d    = mult_lo_nxt;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_DIV: begin
        acc_hi_d = div_rem_nxt;
        acc_lo_d = div_quo_nxt;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          hi_d    = rem_final;
          lo_d    = quo_final;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      acc_hi_q  <= 33'd0;
      acc_lo_q  <= 32'd0;
      booth_x_q <= 1'b0;
      opb_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      booth_x_q <= booth_x_d;
      opb_q     <= opb_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vectors with literal expectations plus a
// cycle-level reference model compared against the outputs on every cycle.
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        div_zero;

  mult_div_unit dut (
    .Clk        (Clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .A          (A),
    .B          (B),
    .HI         (HI),
    .LO         (LO),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state: what the outputs must be after each rising edge.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  int          m_left = 0;
  logic [31:0] r_hi, r_lo;
  longint      mp, mq, mr;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: result computed with plain 64-bit arithmetic at acceptance,
  // published 32 edges later.
  always @(posedge Clk) begin
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hi = r_hi; m_lo = r_lo; m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (start_mult) begin
        mp = longint'($signed(A)) * longint'($signed(B));
        r_hi = mp[63:32]; r_lo = mp[31:0];
        m_busy = 1'b1; m_left = 32; m_dz = 1'b0;
      end else if (start_div) begin
        if (B == 32'd0) begin
          m_dz = 1'b1; m_done = 1'b1;
        end else begin
          mq = longint'($signed(A)) / longint'($signed(B));
          mr = longint'($signed(A)) % longint'($signed(B));
          r_lo = mq[31:0]; r_hi = mr[31:0];
          m_busy = 1'b1; m_left = 32; m_dz = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk32("cyc_HI", HI, m_hi);
      chk32("cyc_LO", LO, m_lo);
      chk1("cyc_busy", busy, m_busy);
      chk1("cyc_done", done, m_done);
      chk1("cyc_div_zero", div_zero, m_dz);
    end
  end

  // Issue one operation from a negedge; returns edges from acceptance to done.
  // glitch_at >= 1 pulses a divide-by-zero start on that cycle of the run.
  task automatic run_op(input bit sm, input bit sd, input logic [31:0] a,
                        input logic [31:0] b, input int glitch_at, output int lat);
    A = a; B = b; start_mult = sm; start_div = sd;
    @(negedge Clk);
    start_mult = 1'b0; start_div = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge Clk);
      lat++;
      if (lat == glitch_at) begin
        start_div = 1'b1; A = 32'd99; B = 32'd0;
      end else if (lat == glitch_at + 1) begin
        start_div = 1'b0;
      end
    end
    start_div = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
    end
  endtask

  logic [31:0] tv_a  [6] = '{32'hFFFF_FFFF, 32'd12345, 32'hFFFF_FF9C, 32'd100, 32'd0, 32'd5};
  logic [31:0] tv_b  [6] = '{32'hFFFF_FFFF, 32'hFFFF_E57B, 32'd7, 32'hFFFF_FFF9, 32'd5, 32'd7};
  bit          tv_ml [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int  lat;
    bit  saw_done;
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; A = 32'd0; B = 32'd0;
    @(negedge Clk);
    chk_en = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    chk32("rst_HI", HI, 32'd0);
    chk32("rst_LO", LO, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_div_zero", div_zero, 1'b0);

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -5, lat);
    chk32("mul_7x-3_latency", 32'(lat), 32'd32);
    chk32("mul_7x-3_HI", HI, 32'hFFFF_FFFF);
    chk32("mul_7x-3_LO", LO, 32'hFFFF_FFEB);

    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -5, lat);
    chk32("mul_max_HI", HI, 32'h3FFF_FFFF);
    chk32("mul_max_LO", LO, 32'h0000_0001);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -5, lat);
    chk32("mul_min_HI", HI, 32'h4000_0000);
    chk32("mul_min_LO", LO, 32'h0000_0000);

    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -5, lat);
    chk32("div_-7/2_latency", 32'(lat), 32'd32);
    chk32("div_-7/2_LO", LO, 32'hFFFF_FFFD);
    chk32("div_-7/2_HI", HI, 32'hFFFF_FFFF);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -5, lat);
    chk32("div_ovf_LO", LO, 32'h8000_0000);
    chk32("div_ovf_HI", HI, 32'h0000_0000);
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, -5, lat);
    chk32("div_7/-2_LO", LO, 32'hFFFF_FFFD);
    chk32("div_7/-2_HI", HI, 32'h0000_0001);

    for (int i = 0; i < 6; i++) begin
      run_op(tv_ml[i], !tv_ml[i], tv_a[i], tv_b[i], -5, lat);
    end

    // Preload HI=0x12, LO=0x34 via 0x692 / 0x20, then divide by zero.
    run_op(1'b0, 1'b1, 32'h0000_0692, 32'h0000_0020, -5, lat);
    chk32("preload_HI", HI, 32'h12);
    chk32("preload_LO", LO, 32'h34);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, -5, lat);
    chk32("dz_latency", 32'(lat), 32'd0);
    chk1("dz_flag", div_zero, 1'b1);
    chk1("dz_busy", busy, 1'b0);
    chk32("dz_HI", HI, 32'h12);
    chk32("dz_LO", LO, 32'h34);
    @(negedge Clk);
    chk1("dz_done_drop", done, 1'b0);
    chk1("dz_sticky", div_zero, 1'b1);

    // Abort a multiply with reset on its 10th cycle.
    A = 32'd123; B = 32'd456; start_mult = 1'b1;
    @(negedge Clk);
    start_mult = 1'b0;
    saw_done = 1'b0;
    repeat (9) begin
      @(negedge Clk);
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    chk1("abort_no_done", saw_done, 1'b0);
    chk32("abort_HI", HI, 32'd0);
    chk32("abort_LO", LO, 32'd0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_div_zero", div_zero, 1'b0);
    @(negedge Clk);
    chk1("abort_done_quiet", done, 1'b0);

    // Both starts together: multiply wins; a start on cycle 5 is ignored.
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 5, lat);
    chk32("prio_latency", 32'(lat), 32'd32);
    chk32("prio_LO", LO, 32'd12);
    chk32("prio_HI", HI, 32'd0);
    chk1("prio_div_zero", div_zero, 1'b0);

    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
